// File: rtl/mem_arb.sv
// Round-robin two-requester arbiter and access sequencer for a single-port memory.
// Optional power-on clear sweep enabled by defining MEM_ARB_CLEAR_EN.
module mem_arb #(
  parameter int unsigned aw = 8,
  parameter int unsigned dw = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [aw-1:0] p0_addr,
  input  logic [dw-1:0] p0_wdata,
  output logic          p0_ack,
  output logic [dw-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [aw-1:0] p1_addr,
  input  logic [dw-1:0] p1_wdata,
  output logic          p1_ack,
  output logic [dw-1:0] p1_rdata,
  output logic [aw-1:0] mem_addr,
  output logic [dw-1:0] mem_wdata,
  output logic          mem_wex,
  output logic          mem_rex,
  input  logic [dw-1:0] mem_rdata,
  output logic          busy
);

`ifdef MEM_ARB_CLEAR_EN
  typedef enum logic [1:0] {StIdle, StAccess, StDone, StClear} state_e;
  localparam logic [aw-1:0] AddrMax = '1;
`else
  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;
`endif

  state_e        state_q, state_d;
  logic          lg_q, lg_d;
  logic          gnt_q, gnt_d;
  logic          we_q, we_d;
  logic [aw-1:0] addr_q, addr_d;
  logic [dw-1:0] wdata_q, wdata_d;
  logic          wex_q, wex_d;
  logic          rex_q, rex_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic [dw-1:0] rd0_q, rd0_d;
  logic [dw-1:0] rd1_q, rd1_d;
  logic          gnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
`ifdef MEM_ARB_CLEAR_EN
      state_q <= StClear;
      wex_q   <= 1'b0;
`else
      state_q <= StIdle;
      wex_q   <= 1'b1;
`endif
      lg_q    <= 1'b1;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rex_q   <= 1'b1;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      state_q <= state_d;
      lg_q    <= lg_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wex_q   <= wex_d;
      rex_q   <= rex_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lg_d    = lg_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wex_d   = wex_q;
    rex_d   = rex_q;
    ack0_d  = ack0_q;
    ack1_d  = ack1_q;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    gnt     = 1'b0;

    case (state_q)
      StIdle: begin
        wex_d = 1'b1;
        rex_d = 1'b1;
        if (p0_req || p1_req) begin
          // On contention the requester that did not win last time goes next.
          gnt     = (p0_req && p1_req) ? ~lg_q : p1_req;
          addr_d  = gnt ? p1_addr : p0_addr;
          wdata_d = gnt ? p1_wdata : p0_wdata;
          we_d    = gnt ? p1_we : p0_we;
          wex_d   = ~we_d;
          rex_d   = we_d;
          lg_d    = gnt;
          gnt_d   = gnt;
          state_d = StAccess;
        end
      end
      StAccess: begin
        if (!we_q) begin
          if (gnt_q) rd1_d = mem_rdata;
          else       rd0_d = mem_rdata;
        end
        wex_d   = 1'b1;
        rex_d   = 1'b1;
        ack0_d  = ~gnt_q;
        ack1_d  = gnt_q;
        state_d = StDone;
      end
      StDone: begin
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        state_d = StIdle;
      end
`ifdef MEM_ARB_CLEAR_EN
      StClear: begin
        wdata_d = '0;
        if (addr_q == AddrMax) begin
          wex_d   = 1'b1;
          addr_d  = '0;
          state_d = StIdle;
        end else begin
          wex_d  = 1'b0;
          addr_d = addr_q + 1'b1;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wex   = wex_q;
  assign mem_rex   = rex_q;
  assign p0_ack    = ack0_q;
  assign p1_ack    = ack1_q;
  assign p0_rdata  = rd0_q;
  assign p1_rdata  = rd1_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_arb.sv
// Scoreboard bench for mem_arb with a behavioural memory; covers MEM_ARB_CLEAR_EN when defined.
module tb_mem_arb;
  localparam int Timeout = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [7:0]  p0_addr, p1_addr, mem_addr;
  logic [15:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata, mem_wdata, mem_rdata;
  logic        p0_ack, p1_ack, mem_wex, mem_rex, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;
  int wex_lows = 0;

  logic [15:0] mem    [256];
  logic [15:0] shadow [256];
  logic [15:0] last_rd [2];
  logic [15:0] exp_q0 [$];
  logic [15:0] exp_q1 [$];
  int          exp_id [$];

  always #5 clk = ~clk;

  mem_arb #(.aw(8), .dw(16)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wex(mem_wex), .mem_rex(mem_rex),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (!mem_wex) mem[mem_addr] <= mem_wdata;
    cycle <= cycle + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  always @(negedge clk) begin
    if (!mem_wex || !mem_rex) check_eq("strobe_excl", {31'b0, mem_wex | mem_rex}, 1);
    if (!mem_wex) wex_lows++;
    if (p0_ack || p1_ack) begin
      check_eq("ack_excl", {31'b0, p0_ack & p1_ack}, 0);
      if (exp_id.size() == 0) check_eq("unexp_ack", {30'b0, p1_ack, p0_ack}, 0);
      else check_eq("grant_id", {31'b0, p1_ack}, exp_id.pop_front());
      if (p0_ack) begin
        if (exp_q0.size() == 0) check_eq("p0_unexp", {31'b0, p0_ack}, 0);
        else check_eq("p0_rdata", {16'b0, p0_rdata}, {16'b0, exp_q0.pop_front()});
      end
      if (p1_ack) begin
        if (exp_q1.size() == 0) check_eq("p1_unexp", {31'b0, p1_ack}, 0);
        else check_eq("p1_rdata", {16'b0, p1_rdata}, {16'b0, exp_q1.pop_front()});
      end
    end
  end

  task automatic drive(input int id, input logic req, input logic we, input logic [7:0] addr,
                       input logic [15:0] wdata);
    if (id == 0) begin
      p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
    end else begin
      p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
    end
  endtask

  // Starts at a negedge; returns the edge that first samples req and the cycle ack is seen.
  task automatic access(input int id, input logic we, input logic [7:0] addr,
                        input logic [15:0] wdata, output int t_req, output int t_ack);
    logic [15:0] exp;
    bit got = 0;
    if (we) begin
      shadow[addr] = wdata;
      exp = last_rd[id];
    end else begin
      exp = shadow[addr];
      last_rd[id] = exp;
    end
    if (id == 0) exp_q0.push_back(exp);
    else exp_q1.push_back(exp);
    drive(id, 1'b1, we, addr, wdata);
    t_req = cycle + 1;
    for (int i = 0; i < Timeout && !got; i++) begin
      @(negedge clk);
      if ((id == 0) ? p0_ack : p1_ack) got = 1;
    end
    if (!got) check_eq("ack_timeout", 0, 1);
    t_ack = cycle;
    drive(id, 1'b0, 1'b0, 8'h00, 16'h0000);
    @(negedge clk);
    check_eq("ack_width", {31'b0, (id == 0) ? p0_ack : p1_ack}, 0);
  endtask

  task automatic wait_clear();
`ifdef MEM_ARB_CLEAR_EN
    int n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_eq("clear_done", {31'b0, busy}, 0);
    for (int i = 0; i < 256; i++) shadow[i] = 16'h0000;
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_addr", {24'b0, mem_addr}, 0);
    check_eq("rst_wdata", {16'b0, mem_wdata}, 0);
    check_eq("rst_rex", {31'b0, mem_rex}, 1);
    check_eq("rst_acks", {30'b0, p1_ack, p0_ack}, 0);
    check_eq("rst_rdata", {p1_rdata, p0_rdata}, 0);
`ifdef MEM_ARB_CLEAR_EN
    check_eq("rst_busy", {31'b0, busy}, 1);
    check_eq("rst_wex", {31'b0, mem_wex}, 0);
`else
    check_eq("rst_busy", {31'b0, busy}, 0);
    check_eq("rst_wex", {31'b0, mem_wex}, 1);
`endif
    rst = 1'b1;
    last_rd[0] = 16'h0000;
    last_rd[1] = 16'h0000;
    wait_clear();
  endtask

  int tr0, ta0, tr1, ta1;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'h0000;
      shadow[i] = 16'h0000;
    end
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, 8'h00, 16'h0000);
    drive(1, 1'b0, 1'b0, 8'h00, 16'h0000);
    do_reset();

    // Single write then read
    @(negedge clk);
    wex_lows = 0;
    exp_id.push_back(0);
    access(0, 1'b1, 8'h12, 16'hA5A5, tr0, ta0);
    check_eq("wr_latency", ta0 - tr0, 1);
    check_eq("wex_one_cycle", wex_lows, 1);
    exp_id.push_back(0);
    access(0, 1'b0, 8'h12, 16'h0000, tr0, ta0);
    check_eq("rd_latency", ta0 - tr0, 1);
    check_eq("rd_value", {16'b0, p0_rdata}, 32'hA5A5);
    check_eq("wex_after_rd", wex_lows, 1);

    // Contention right after reset: p0 wins
    do_reset();
    @(negedge clk);
    exp_id.push_back(0);
    exp_id.push_back(1);
    fork
      access(0, 1'b0, 8'h12, 16'h0000, tr0, ta0);
      access(1, 1'b0, 8'h12, 16'h0000, tr1, ta1);
    join
    check_eq("contend_gap", ta1 - ta0, 3);
    check_eq("contend_lat", ta0 - tr0, 1);

    // Sustained contention alternates
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      exp_id.push_back(0);
      exp_id.push_back(1);
    end
    fork
      begin
        access(0, 1'b1, 8'h20, 16'h1111, tr0, ta0);
        access(0, 1'b0, 8'h20, 16'h0000, tr0, ta0);
        access(0, 1'b1, 8'h21, 16'h2222, tr0, ta0);
      end
      begin
        access(1, 1'b1, 8'h30, 16'h3333, tr1, ta1);
        access(1, 1'b0, 8'h30, 16'h0000, tr1, ta1);
        access(1, 1'b0, 8'h31, 16'h0000, tr1, ta1);
      end
    join
    check_eq("sustain_drain", exp_id.size(), 0);

    // Independent read data per requester
    @(negedge clk);
    exp_id.push_back(1);
    access(1, 1'b1, 8'h00, 16'h1234, tr1, ta1);
    exp_id.push_back(0);
    access(0, 1'b0, 8'h00, 16'h0000, tr0, ta0);
    check_eq("indep_p0", {16'b0, p0_rdata}, 32'h1234);
    check_eq("indep_p1", {16'b0, p1_rdata}, {16'b0, last_rd[1]});

    // Reset during ACCESS of a p1 write
    @(negedge clk);
    drive(1, 1'b1, 1'b1, 8'h40, 16'hBEEF);
    @(negedge clk);
    check_eq("abort_busy_acc", {31'b0, busy}, 1);
    check_eq("abort_wex_acc", {31'b0, mem_wex}, 0);
    rst = 1'b0;
    drive(1, 1'b0, 1'b0, 8'h00, 16'h0000);
    @(negedge clk);
    check_eq("abort_ack", {31'b0, p1_ack}, 0);
    check_eq("abort_rdata", {p1_rdata, p0_rdata}, 0);
`ifdef MEM_ARB_CLEAR_EN
    check_eq("abort_busy", {31'b0, busy}, 1);
`else
    check_eq("abort_busy", {31'b0, busy}, 0);
    check_eq("abort_wex", {31'b0, mem_wex}, 1);
`endif
    rst = 1'b1;
    last_rd[0] = 16'h0000;
    last_rd[1] = 16'h0000;
    wait_clear();
    @(negedge clk);
    exp_id.push_back(1);
    access(1, 1'b0, 8'h12, 16'h0000, tr1, ta1);
    check_eq("post_abort_lat", ta1 - tr1, 1);

`ifdef MEM_ARB_CLEAR_EN
    // Clear sweep with a request held throughout
    begin
      int bcnt = 0;
      bit got = 0;
      exp_id.push_back(0);
      access(0, 1'b1, 8'hFF, 16'hFFFF, tr0, ta0);
      for (int i = 0; i < 256; i++) shadow[i] = 16'h0000;
      last_rd[0] = 16'h0000;
      last_rd[1] = 16'h0000;
      exp_id.push_back(0);
      exp_q0.push_back(16'h0000);
      drive(0, 1'b1, 1'b0, 8'h00, 16'h0000);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      while (busy && bcnt < 400) begin
        check_eq("ack_in_clear", {31'b0, p0_ack}, 0);
        bcnt++;
        @(negedge clk);
      end
      check_eq("clear_cycles", bcnt, 256);
      for (int i = 0; i < Timeout && !got; i++) begin
        if (p0_ack) got = 1;
        else @(negedge clk);
      end
      check_eq("clear_held_ack", {31'b0, got}, 1);
      drive(0, 1'b0, 1'b0, 8'h00, 16'h0000);
      @(negedge clk);
      exp_id.push_back(0);
      access(0, 1'b0, 8'hFF, 16'h0000, tr0, ta0);
      check_eq("clear_ff", {16'b0, p0_rdata}, 0);
    end
`endif

    repeat (4) @(negedge clk);
    check_eq("sb_empty", exp_q0.size() + exp_q1.size() + exp_id.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
Name: mem_arb

Overview:
- Two-requester arbiter and access sequencer for the single-port mem block (aw/dw parameterised, active-low wex/rex strobes, asynchronous rdata).
- Sits between the mem instance and two client blocks, e.g. the ia address sequencer and a host/test port.
- Serialises accesses with round-robin fairness and drives mem's addr/wdata/wex/rex.
- Returns read data with a one-cycle ack pulse per access.

Parameters:
aw, 8, address width (mem depth = 1<<aw)
dw, 16, data width

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-low (rst=0 at a rising edge resets)
p0_req  input  1  requester 0 access request, held until p0_ack
p0_we  input  1  requester 0: 1=write, 0=read
p0_addr  input  aw  requester 0 address
p0_wdata  input  dw  requester 0 write data
p0_ack  output  1  requester 0 completion pulse, one cycle
p0_rdata  output  dw  requester 0 read data, valid from p0_ack onward
p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_rdata  as above for requester 1
mem_addr  output  aw  to mem addr
mem_wdata  output  dw  to mem wdata
mem_wex  output  1  to mem wex, active-low write strobe
mem_rex  output  1  to mem rex, active-low read strobe
mem_rdata  input  dw  from mem rdata (combinational)
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset values: mem_addr=0, mem_wdata=0, mem_wex=1, mem_rex=1, p0_ack=p1_ack=0, p0_rdata=p1_rdata=0, busy=0 (busy=1 with the clear option), state=IDLE, last-grant pointer lg=1.
- FSM states: IDLE, ACCESS, DONE (plus CLEAR, optional only).
- IDLE, no req: outputs hold; mem_wex=mem_rex=1.
- IDLE, any req at edge k:
  - Arbitration picks requester g.
  - Registers g's addr and wdata into mem_addr/mem_wdata.
  - Drives mem_wex=0 if we=1, else mem_rex=0.
  - Sets lg=g, goes to ACCESS.
- Arbitration rule:
  - Only one req high: grant it.
  - Both high: grant the requester != lg.
  - After reset, p0 wins the first contention.
- ACCESS (exactly one cycle), at the exiting edge:
  - Read: capture mem_rdata into pg_rdata.
  - Write: pg_rdata unchanged.
  - Set mem_wex=mem_rex=1 and pulse pg_ack=1; go to DONE.
- DONE (one cycle):
  - pg_ack high for this cycle only.
  - Requester drops req (or issues a new one) by the end of this cycle.
  - Next edge: ack=0, go to IDLE.
  - req is not sampled in DONE.
- Latency and throughput:
  - req first sampled at edge k: strobe low during cycle k..k+1, ack high during cycle k+1..k+2.
  - Maximum throughput is one access per 3 cycles.
- Strobes: mem_wex and mem_rex are never low simultaneously; each is low for exactly one cycle per access.
- Address: used unmodified, no wrap logic.
- Non-granted requester: keeps req high, is served next IDLE (no starvation).
  - With both held continuously, grants alternate p0,p1,p0,...
- Reset mid-operation (rst=0 in ACCESS or DONE):
  - Aborts the access; all outputs return to reset values at that edge.
  - No ack is issued; rdata is cleared.
- req changing while in ACCESS/DONE: ignored; granted fields were registered at grant.

Optional Feature:
- Macro: MEM_ARB_CLEAR_EN.
- Defined:
  - Reset enters CLEAR with busy=1.
  - Writes mem_wdata=0 to addresses 0..(1<<aw)-1, one address per cycle (mem_wex=0 each cycle, mem_addr incrementing).
  - After the last address (255 for aw=8): mem_wex=1, mem_addr=0, go to IDLE, busy=0.
  - Requests during CLEAR are held off (no ack), then arbitrated normally.
  - Reset during CLEAR restarts the clear from address 0.
- Undefined: the CLEAR state does not exist; reset goes directly to IDLE with busy=0.

Test Plan:
- Single write, then read: p0 write addr=8'h12 wdata=16'hA5A5, then p0 read addr=8'h12 -> p0_ack one cycle, 2 edges after each req; p0_rdata=16'hA5A5; mem_wex low exactly one cycle.
- Contention after reset: p0 and p1 both read at the same edge -> p0 acked first, p1 acked 3 cycles later.
- Sustained contention: both hold req for 6 accesses -> grants p0,p1,p0,p1,p0,p1; p0_ack and p1_ack are never high together.
- Independent read data: p1 writes 16'h1234 to addr 8'h00; p0 reads addr 8'h00 -> p0_rdata=16'h1234; p1_rdata unchanged on its write ack.
- Reset abort: rst=0 during ACCESS of a p1 write -> no p1_ack; mem_wex=1 and busy=0 at that edge (busy=1 under MEM_ARB_CLEAR_EN); next request served normally.
- Clear sweep (MEM_ARB_CLEAR_EN): preload addr 8'hFF=16'hFFFF, pulse reset -> busy high 256 cycles; a p0 req held throughout is acked only after busy falls; reads of 8'h00 and 8'hFF return 16'h0000.
